// File: rtl/bch63_pkg.sv
// Shared constants, state encoding and a reference parity function for the BCH(63,56) code.
// The generator is g(x) = x^7 + x^6 + x^2 + 1 = (x+1)(x^6+x+1).
package bch63_pkg;

    localparam int N = 63;
    localparam int K = 56;
    localparam int M = 7;

    localparam logic [7:0] G_POLY = 8'hC5;
    localparam logic [6:0] G_LOW  = 7'h45;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Parity of a full message, MSB first, using the same division the hardware performs.
    function automatic logic [M-1:0] parity_of(input logic [K-1:0] message);
        logic [M-1:0] p;
        logic         fb;
        p = '0;
        for (int i = K - 1; i >= 0; i--) begin
            fb = message[i] ^ p[M-1];
            p  = {p[M-2:0], 1'b0} ^ ({M{fb}} & G_LOW);
        end
        return p;
    endfunction

endpackage

// File: rtl/bch63_parity_lfsr.sv
// Bit-serial 7-bit LFSR dividing the incoming message stream by g(x).
// The remainder left after the last message bit is the systematic parity.
module bch63_parity_lfsr
    import bch63_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         data,
    output logic [M-1:0] parity
);

    logic fb;

    assign fb = data ^ parity[M-1];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            parity <= '0;
        end else if (enable) begin
            // NOTE: non-blocking here so every tap sees the pre-shift register value.
            parity <= {parity[M-2:0], 1'b0} ^ ({M{fb}} & G_LOW);
        end
    end

endmodule

// File: rtl/bch63_encoder.sv
// Systematic BCH(63,56) encoder: captures a message, streams it MSB first through the
// parity LFSR for 56 cycles, then holds {msg, parity} until the downstream accepts it.
module bch63_encoder
    import bch63_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   msg,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   codeword,
    output logic           busy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [5:0] LAST_BIT = 6'(K - 1);

    logic [1:0]   state;
    logic [K-1:0] msg_reg;
    logic [5:0]   counter;
    logic [M-1:0] parity;
    logic         accept;

    assign accept = (state == ST_IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            msg_reg <= '0;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        msg_reg <= msg;
                        counter <= LAST_BIT;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (counter == 6'd0) begin
                        state <= ST_DONE;
                    end else begin
                        counter <= counter - 6'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Parity is cleared on the accept edge so an aborted or previous encode leaves no residue.
    bch63_parity_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state == ST_SHIFT),
        .data   (msg_reg[counter]),
        .parity (parity)
    );

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SHIFT);
    assign out_valid = (state == ST_DONE);
    assign codeword  = out_valid ? {msg_reg, parity} : '0;

endmodule

// File: tb/tb_bch63_encoder.sv
// Scoreboard bench for bch63_encoder: the driver queues expected codewords on acceptance,
// a monitor pops and checks each codeword as it is handed downstream.
module tb_bch63_encoder;
    import bch63_pkg::*;

    localparam logic [7:0] TB_G = 8'hC5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] msg;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] codeword;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [62:0] sb[$];
    logic [62:0] last_cw = '0;
    int          popped = 0;
    logic        rand_ready = 1'b0;

    always #5 clk = ~clk;

    bch63_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remainder of a 63-bit word modulo g(x) by plain long division.
    function automatic logic [6:0] rem63(input logic [62:0] w);
        logic [62:0] r;
        r = w;
        for (int i = 62; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ TB_G;
        end
        return r[6:0];
    endfunction

    function automatic logic [62:0] exp_cw(input logic [55:0] m);
        return {m, rem63({m, 7'b0})};
    endfunction

    // Monitor: a transfer happens on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0h with empty scoreboard", codeword);
            end else begin
                logic [62:0] e;
                e = sb.pop_front();
                check("codeword", 64'(codeword), 64'(e));
                check("even_weight", 64'(^codeword), 64'd0);
                check("syndrome_zero", 64'(rem63(codeword)), 64'd0);
                last_cw = codeword;
                popped++;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Enters and leaves two time units after a rising edge.
    task automatic send(input logic [55:0] m, input logic [62:0] e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        msg = m;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                check("pkg_parity", 64'(parity_of(m)), 64'(e[6:0]));
                done = 1'b1;
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int          idle_negs;
        int          busy_negs;
        int          popped_before;
        int          dups;
        logic [63:0] r;
        logic [62:0] f;
        logic [6:0]  syn[63];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        msg = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_codeword", 64'(codeword), 64'd0);
        @(posedge clk);
        #2;

        // All-zero message: latency and busy window.
        in_valid = 1'b1;
        msg = 56'h0;
        @(negedge clk);
        check("zero_accept_ready", 64'(in_ready), 64'd1);
        sb.push_back(63'h0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        idle_negs = 0;
        busy_negs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            idle_negs++;
            if (busy) busy_negs++;
        end
        check("latency_cycles", 64'(idle_negs), 64'd56);
        check("busy_cycles", 64'(busy_negs), 64'd56);
        @(negedge clk);
        check("in_ready_return", 64'(in_ready), 64'd1);
        check("out_valid_fall", 64'(out_valid), 64'd0);
        @(posedge clk);
        #2;
        drain();

        // Hand-computed unit vectors; parity of msg 3 is 0x45 ^ 0x4F = 0x0A.
        send(56'h1, 63'h0C5);
        send(56'h2, 63'h14F);
        send(56'h3, 63'h18A);
        drain();

        // Backpressure: codeword holds, no second capture.
        out_ready = 1'b0;
        send(56'h1, 63'h0C5);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 20; i++) begin
            in_valid = ~in_valid;
            msg = {$urandom(), $urandom()};
            @(negedge clk);
            check("hold_codeword", 64'(codeword), 64'h0C5);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        popped_before = popped;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_one_pop", 64'(popped - popped_before), 64'd1);
        check("no_second_capture", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        // Reset in the middle of SHIFT discards the in-flight message.
        in_valid = 1'b1;
        msg = 56'hA5_5A3C_C3F0_0F96;
        @(negedge clk);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #2;
        send(56'h1, 63'h0C5);
        drain();

        // Back-to-back random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom(), $urandom()};
            send(r[55:0], exp_cw(r[55:0]));
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;

        // Single-bit flips of the last emitted codeword.
        dups = 0;
        for (int i = 0; i < 63; i++) begin
            f = last_cw ^ (63'd1 << i);
            syn[i] = rem63(f);
            check("flip_nonzero", 64'(syn[i] != 7'd0), 64'd1);
            check("flip_odd_w", 64'(^f), 64'd1);
        end
        for (int i = 0; i < 63; i++) begin
            for (int j = i + 1; j < 63; j++) begin
                if (syn[i] == syn[j]) dups++;
            end
        end
        check("flip_distinct", 64'(dups), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bch63_encoder.md
Name: bch63_encoder

Overview:
- Systematic BCH(63,56) encoder; transmit-side counterpart of the bit-serial syndrome checker.
- Accepts a 56-bit message and computes 7 parity bits with a bit-serial LFSR dividing by g(x) = x^7+x^6+x^2+1 (8'hC5).
- Presents the 63-bit codeword in the layout the receive path consumes: codeword[62:7] = message, codeword[6:0] = parity, bit i = coefficient of x^i.
- Output feeds the error-injection/channel stage ahead of the syndrome block.

Parameters:
- G_LOW, 7'h45, low 7 coefficients of g(x) (x^6+x^2+1); x^7 is implicit.
- K, 56, message length in bits; fixed for this code.
- M, 7, parity length in bits; fixed for this code.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  message valid.
- in_ready  out  1  block can accept a message.
- msg  in  56  message; msg[55] is the highest-degree coefficient.
- out_valid  out  1  codeword valid; held until accepted.
- out_ready  in  1  downstream accepts codeword.
- codeword  out  63  {msg, parity}.
- busy  out  1  high while in LOAD/SHIFT.

Behaviour:
- Reset, when rst=1 at a clk edge:
  - state=IDLE, parity reg=0, msg reg=0, bit counter=0.
  - in_ready=1, out_valid=0, busy=0, codeword=0.
  - Reset dominates every other input, including mid-SHIFT and mid-DONE; the in-flight message is discarded.
- States:
  - IDLE: in_ready=1. When in_valid=1, capture msg into msg_reg, clear parity to 0, set counter=55, go to SHIFT. in_ready drops the next cycle.
  - SHIFT: one message bit per clock, MSB first (msg_reg[counter]).
    - fb = msg_reg[counter] ^ p[6].
    - p <= {p[5:0],1'b0} ^ ({7{fb}} & G_LOW).
    - At counter==0, perform the final step and go to DONE; otherwise decrement counter.
    - Exactly 56 SHIFT cycles.
  - DONE: out_valid=1, codeword={msg_reg,p} held stable. On out_valid&&out_ready, go to IDLE; out_valid falls the next cycle.
- Latency:
  - Accept edge at cycle 0; SHIFT covers cycles 1..56; out_valid=1 from cycle 57.
  - With out_ready tied high, in_ready returns at cycle 58. Throughput is 1 codeword per 58 cycles.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; no queuing, and msg is not sampled.
  - codeword and out_valid must not change while out_valid=1 && out_ready=0.
  - out_ready while out_valid=0 has no effect.
- Widths:
  - counter is 6 bits and counts down 55..0; it never wraps.
  - Parity register is 7 bits; all XOR arithmetic is GF(2).
- Invariants, checked by assertions:
  - Every emitted codeword is divisible by g(x).
  - Every emitted codeword has even Hamming weight, because (x+1) divides g.
  - Feeding the codeword to the syndrome block yields S=0, w=0.
- busy = (state==SHIFT); a LOAD phase is merged into the IDLE accept edge.

Decomposition:
- Shared package bch63_pkg holds:
  - constants N=63, K=56, M=7, G_POLY=8'hC5, G_LOW=7'h45;
  - state enum {IDLE, SHIFT, DONE};
  - a function computing the full parity of a 56-bit message, for the bench golden model.
- The syndrome side imports the same G_POLY.
- One natural sub-module: bch63_parity_lfsr. It is the 7-bit LFSR with clear, enable and serial data in, exposing p[6:0]. The FSM and counter live in bch63_encoder.

Test Plan:
- Reset, then msg=56'h0 -> after 57 cycles out_valid=1, codeword=63'h0. Cycles 1..57 show busy for 56 cycles.
- msg=56'h1 -> codeword=63'h0C5 (parity 7'h45). msg=56'h2 -> 63'h14F. msg=56'h3 -> 63'h18A, confirming linearity 0x45^0x4F=0x0A.
- Hold out_ready=0 for 20 cycles after DONE, toggling in_valid and msg -> codeword stable, in_ready=0, no second capture. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst at SHIFT cycle 30 -> next cycle state=IDLE, out_valid=0, in_ready=1. A new msg=56'h1 then yields 63'h0C5 with no residue from the aborted encode.
- 1000 random messages back-to-back, out_ready random -> each codeword matches the package golden model, has even weight, and gives S=7'h0 through the syndrome block.
- Single-bit flip of each of the 63 positions of a random codeword into the syndrome block -> nonzero, distinct syndromes, each with odd w.
